fp_div_seq: RTL
===============

Name: fp_div_seq

Overview:
Iterative IEEE-754 single-precision divider, result = a / b. It is the inverse companion of the ALU's combinational float multiply, and is too slow to be combinational, so it runs as a multi-cycle unit beside the ALU. The operand side and the result side each use a valid/ready handshake. One division is in flight at a time.

Parameters:
QBITS, 26, number of quotient bits generated: 24 significand bits + guard + one spare for normalisation; must stay 26.
NAN_CANON, 32'h7fc00000, value returned for every NaN result.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operands offered
in_ready  out  1  unit idle and can accept operands
a  in  32  dividend, fp32
b  in  32  divisor, fp32
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  32  quotient, fp32

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high on clk.
- State after any clk edge with rst=1:
  - state=IDLE
  - out_valid=0
  - result=0
  - all internal registers cleared
  - in_ready=1 from the following cycle
- Reset mid-operation (any state): the operation is abandoned, nothing is emitted, and out_valid stays low.
- in_ready = (state==IDLE), decoded from state.
- Accept occurs on an edge where in_valid & in_ready. a and b are registered on that edge; the unit then enters UNPACK.
- UNPACK (1 cycle):
  - Split sign, exponent and fraction.
  - Denormal inputs are flushed to signed zero.
  - sign = sa ^ sb.
  - Special results, in priority order, go straight to DONE:
    - either input NaN -> NAN_CANON
    - 0/0 -> NAN_CANON
    - inf/inf -> NAN_CANON
    - x/0 (x nonzero) -> signed inf
    - inf/x -> signed inf
    - 0/x -> signed zero
    - x/inf -> signed zero
  - Otherwise: exp = ea - eb + 127 (10-bit signed), ma = {1,fa}, mb = {1,fb}, rem = ma, cnt = 0, then go to DIVIDE.
- DIVIDE (QBITS=26 cycles): restoring division, one quotient bit per cycle, MSB first.
  - If rem >= mb: q bit = 1 and rem = rem - mb.
  - rem is then shifted left by 1.
  - Leave DIVIDE when cnt==25.
- ROUND (1 cycle):
  - If Q[25]=1: mant = Q[25:2], guard = Q[1], sticky = Q[0] | (rem != 0).
  - Else: mant = Q[24:1], guard = Q[0], sticky = (rem != 0), and exp = exp - 1.
  - Round to nearest, ties to even: increment when guard & (sticky | mant[0]).
  - If the increment carries to 2^24, shift mant right and exp = exp + 1.
  - exp >= 255 -> signed inf.
  - exp <= 0 -> signed zero (flush-to-zero, no denormal output).
  - Go to DONE.
- DONE:
  - out_valid=1 and result is held stable while out_ready=0.
  - On out_valid & out_ready, go to IDLE; in_ready rises the next cycle, with no same-cycle bypass.
- Latency is measured from the accept edge to out_valid high:
  - normal operands: 28 cycles
  - special operands: 2 cycles
- Throughput: one result per latency + 2 cycles when out_ready is held high.
- in_valid and operand changes outside IDLE are ignored.

Optional Feature:
FPDIV_EXC_FLAGS_EN
- Defined: adds output flags[4:0] = {invalid, div_by_zero, overflow, underflow, inexact}.
  - Valid with out_valid and held with result.
  - invalid: NaN result.
  - div_by_zero: finite nonzero / 0.
  - overflow: rounded exp >= 255.
  - underflow: result flushed to zero from a nonzero quotient.
  - inexact: guard | sticky, or overflow/underflow.
  - Cleared by reset.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fp_pkg:
  - FP_BIAS=127, FP_EXP_W=8, FP_FRAC_W=23
  - FP_QNAN=32'h7fc00000, FP_PINF=32'h7f800000, FP_NINF=32'hff800000
  - state enum: IDLE, UNPACK, DIVIDE, ROUND, DONE
  - flag bit indices
- One sub-module, fp_round_pack (combinational): takes sign, signed exp, 26-bit Q and rem-nonzero; returns the packed fp32 and raw flags. It is reusable by the multiplier.

Test Plan:
- 10.0/4.0: a=41200000, b=40800000 -> result 40200000, out_valid exactly 28 cycles after accept.
- 1.0/3.0: 3f800000 / 40400000 -> 3eaaaaab (round-up path); -6.0/2.0: c0c00000 / 40000000 -> c0400000.
- Specials, each with 2-cycle latency:
  - 3f800000 / 00000000 -> 7f800000
  - bf800000 / 00000000 -> ff800000
  - 00000000 / 00000000 -> 7fc00000
  - 7f800000 / 7f800000 -> 7fc00000
  - 7fc00000 / 3f800000 -> 7fc00000
  - 00000000 / 40000000 -> 00000000
- Range limits:
  - 7f7fffff / 3f000000 -> 7f800000 (overflow flag if enabled)
  - 00800000 / 40000000 -> 00000000 (underflow flag if enabled)
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: result stable, in_ready=0, a new in_valid ignored. Then out_ready=1 -> in_ready=1 on the next cycle.
- Reset mid-operation: assert rst during the 10th DIVIDE cycle. Required: out_valid never rises for that operation, in_ready=1 the cycle after reset. A following 2.5/4.0 (40200000 / 40800000) returns 3f200000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared fp32 definitions for the divider and round/pack logic.
// Flag bit positions match the optional flags port (FPDIV_EXC_FLAGS_EN).
package fp_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;

  localparam logic [31:0] FP_QNAN = 32'h7fc00000;
  localparam logic [31:0] FP_PINF = 32'h7f800000;
  localparam logic [31:0] FP_NINF = 32'hff800000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    DIVIDE,
    ROUND,
    DONE
  } state_t;

  localparam int FL_INV = 4;
  localparam int FL_DZ  = 3;
  localparam int FL_OVF = 2;
  localparam int FL_UNF = 1;
  localparam int FL_NX  = 0;

  function automatic logic [31:0] fp_inf(
    input logic s
  );
    return s ? FP_NINF : FP_PINF;
  endfunction

  function automatic logic [31:0] fp_zero(
    input logic s
  );
    return {s, 31'd0};
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise a 26-bit quotient, round to nearest even and pack to fp32.
// Flush-to-zero on underflow, signed infinity on overflow.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] expo,
  input  logic [25:0]       q,
  input  logic              rem_nz,
  output logic [31:0]       res,
  output logic [4:0]        flags
);

  logic [23:0]       mant;
  logic              g;
  logic              s;
  logic              inc;
  logic [24:0]       sum;
  logic signed [9:0] e1;
  logic signed [9:0] e2;
  logic [22:0]       frac;

  always_comb begin
    mant = '0;
    g    = 1'b0;
    s    = 1'b0;
    e1   = expo;
    if (q[25]) begin
      mant = q[25:2];
      g    = q[1];
      s    = q[0] | rem_nz;
      e1   = expo;
    end else begin
      mant = q[24:1];
      g    = q[0];
      s    = rem_nz;
      e1   = expo - 10'sd1;
    end

    inc = g & (s | mant[0]);
    sum = {1'b0, mant} + {24'd0, inc};

    // Carry out of rounding means the mantissa became exactly 2.0
    if (sum[24]) begin
      frac = sum[23:1];
      e2   = e1 + 10'sd1;
    end else begin
      frac = sum[22:0];
      e2   = e1;
    end

    flags        = '0;
    flags[FL_NX] = g | s;
    if (e2 >= 10'sd255) begin
      res           = fp_inf(sign);
      flags[FL_OVF] = 1'b1;
      flags[FL_NX]  = 1'b1;
    end else if (e2 <= 10'sd0) begin
      res           = fp_zero(sign);
      flags[FL_UNF] = 1'b1;
      flags[FL_NX]  = 1'b1;
    end else begin
      res = {sign, e2[7:0], frac};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative fp32 divider (restoring, one quotient bit per cycle).
// Optional flags output enabled by FPDIV_EXC_FLAGS_EN.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int          QBITS     = 26,
  parameter logic [31:0] NAN_CANON = 32'h7fc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
`ifdef FPDIV_EXC_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);

  state_t            state;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [23:0]       mb_q;
  logic [24:0]       rem_q;
  logic [25:0]       q_q;
  logic [4:0]        cnt_q;
  logic              spec_q;
  logic [31:0]       spec_res_q;

  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [22:0] fa;
  logic [22:0] fb;
  logic        sgn;
  logic        a_zero;
  logic        b_zero;
  logic        a_inf;
  logic        b_inf;
  logic        a_nan;
  logic        b_nan;

  logic        sp;
  logic [31:0] sp_res;
  logic [4:0]  sp_fl;

  logic        ge;
  logic [24:0] diff;
  logic [24:0] rem_next;

  logic [31:0] rp_res;
  logic [4:0]  rp_flags;

  assign in_ready = (state == IDLE);

  assign ea  = a_q[30:23];
  assign eb  = b_q[30:23];
  assign fa  = a_q[22:0];
  assign fb  = b_q[22:0];
  assign sgn = a_q[31] ^ b_q[31];

  // Denormals share exponent 0 and are treated as zero
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hff) && (fa == '0);
  assign b_inf  = (eb == 8'hff) && (fb == '0);
  assign a_nan  = (ea == 8'hff) && (fa != '0);
  assign b_nan  = (eb == 8'hff) && (fb != '0);

  always_comb begin
    sp     = 1'b1;
    sp_res = '0;
    sp_fl  = '0;
    if (a_nan || b_nan) begin
      sp_res        = NAN_CANON;
      sp_fl[FL_INV] = 1'b1;
    end else if (a_zero && b_zero) begin
      sp_res        = NAN_CANON;
      sp_fl[FL_INV] = 1'b1;
    end else if (a_inf && b_inf) begin
      sp_res        = NAN_CANON;
      sp_fl[FL_INV] = 1'b1;
    end else if (b_zero) begin
      sp_res       = fp_inf(sgn);
      sp_fl[FL_DZ] = !a_inf;
    end else if (a_inf) begin
      sp_res = fp_inf(sgn);
    end else if (a_zero) begin
      sp_res = fp_zero(sgn);
    end else if (b_inf) begin
      sp_res = fp_zero(sgn);
    end else begin
      sp = 1'b0;
    end
  end

  assign ge       = (rem_q >= {1'b0, mb_q});
  assign diff     = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
  assign rem_next = diff << 1;

  fp_round_pack u_round (
    .sign   (sign_q),
    .expo   (exp_q),
    .q      (q_q),
    .rem_nz (|rem_q),
    .res    (rp_res),
    .flags  (rp_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mb_q       <= '0;
      rem_q      <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      out_valid  <= 1'b0;
      result     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q     <= sgn;
          spec_q     <= sp;
          spec_res_q <= sp_res;
          exp_q      <= $signed({2'b00, ea})
                      - $signed({2'b00, eb})
                      + 10'sd127;
          mb_q       <= {1'b1, fb};
          rem_q      <= {2'b01, fa};
          q_q        <= '0;
          cnt_q      <= '0;
          // Specials skip the iteration and take the result register slot
          state      <= sp ? ROUND : DIVIDE;
        end
        DIVIDE: begin
          q_q   <= {q_q[24:0], ge};
          rem_q <= rem_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(QBITS - 1)) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          result    <= spec_q ? spec_res_q : rp_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPDIV_EXC_FLAGS_EN
  logic [4:0] spec_fl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_fl_q <= '0;
      flags     <= '0;
    end else begin
      if (state == UNPACK) begin
        spec_fl_q <= sp_fl;
      end
      if (state == ROUND) begin
        flags <= spec_q ? spec_fl_q : rp_flags;
      end
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^{sp_fl, rp_flags};
`endif

endmodule
